logic_result_queue: RTL and testbench

LOGIC_RESULT_QUEUE -- requirements
Module: logic_result_queue

---
 rtl/logic_result_queue.sv | 89 ++++++++
 tb/tb_logic_result_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/logic_result_queue.sv
// Result FIFO behind the bitwise OR/AND/XOR unit: valid/ready on both sides,
// per-entry zero tag, sticky zero_seen flag and a synchronous flush.
module logic_result_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     zero_seen,
  input  logic                     clear
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_zero;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_zero_seen;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_in_zero;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == CNT_W'(0));
  assign w_push    = in_valid & ~w_full & ~clear;
  assign w_pop     = out_ready & ~w_empty & ~clear;
  assign w_in_zero = (in_data == '0);

  // Handshake and head outputs depend on registered state only.
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign out_zero  = ~w_empty & r_zero[r_rptr];
  assign count     = r_count;
  assign zero_seen = r_zero_seen;

  // Storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr]  <= in_data;
      r_zero[r_wptr] <= w_in_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_zero_seen <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_zero_seen <= 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_in_zero) begin
        r_zero_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_logic_result_queue.sv
// Directed plus random stimulus against a queue-based reference model of the
// result FIFO; every cycle compares handshake, head, count and zero_seen.
module tb_logic_result_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [2:0]       count;
  logic             zero_seen;
  logic             clear;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb[$];
  logic        m_zs = 1'b0;

  logic_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .count     (count),
    .zero_seen (zero_seen),
    .clear     (clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Compare outputs against the model, advance the model, then take one edge.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    #2;
    chk("in_ready",  32'(in_ready),  32'(sb.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
    chk("count",     32'(count),     32'(sb.size()));
    chk("zero_seen", 32'(zero_seen), 32'(m_zs));
    if (sb.size() == 0) begin
      chk("out_data_empty", out_data,        32'h0);
      chk("out_zero_empty", 32'(out_zero),   32'h0);
    end else begin
      chk("out_data", out_data,      sb[0]);
      chk("out_zero", 32'(out_zero), 32'(sb[0] == 32'h0));
    end
    if (!rst_n || clear) begin
      sb.delete();
      m_zs = 1'b0;
    end else begin
      do_push = in_valid && (sb.size() < DEPTH);
      do_pop  = out_ready && (sb.size() > 0);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back(in_data);
        if (in_data == 32'h0) m_zs = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();

    // Fill to full, overflow attempt, drain in order.
    drive(1'b1, 32'h0000000F, 1'b0); cycle();
    drive(1'b1, 32'h000000F0, 1'b0); cycle();
    drive(1'b1, 32'h00000F00, 1'b0); cycle();
    drive(1'b1, 32'h0000F000, 1'b0); cycle();
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hFFFFFFFF, 1'b0); cycle();
    chk("overflow_head", out_data, 32'h0000000F);
    drive(1'b0, 32'h0, 1'b1);
    repeat (5) cycle();
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Zero tagging.
    drive(1'b1, 32'h00000000, 1'b0); cycle();
    drive(1'b1, 32'h80000000, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b0); cycle();
    chk("zero_head", 32'(out_zero), 32'd1);
    chk("zero_seen_set", 32'(zero_seen), 32'd1);
    drive(1'b0, 32'h0, 1'b1); cycle();
    chk("after_pop_data", out_data, 32'h80000000);
    chk("after_pop_zero", 32'(out_zero), 32'd0);
    chk("zero_seen_sticky", 32'(zero_seen), 32'd1);
    cycle();

    // Simultaneous push/pop at count 2 over several pointer wraps.
    drive(1'b1, 32'h100, 1'b0); cycle();
    drive(1'b1, 32'h101, 1'b0); cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h102 + 32'(i), 1'b1);
      cycle();
      chk("pp_count", 32'(count), 32'd2);
    end
    drive(1'b0, 32'h0, 1'b1);
    repeat (3) cycle();

    // Full with pop: no push that edge, push accepted on the next.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 1'b0);
      cycle();
    end
    drive(1'b1, 32'h0000AAAA, 1'b1); cycle();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h0000BBBB, 1'b0); cycle();
    chk("refill_count", 32'(count), 32'd4);
    drive(1'b0, 32'h0, 1'b1);
    repeat (5) cycle();

    // Clear with a same-cycle push, then mid-operation reset.
    drive(1'b1, 32'h0, 1'b0); cycle();
    drive(1'b1, 32'h1, 1'b0); cycle();
    drive(1'b1, 32'h2, 1'b0); cycle();
    drive(1'b1, 32'h5, 1'b1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_zs", 32'(zero_seen), 32'd0);
    chk("clear_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h0, 1'b0); cycle();
    drive(1'b1, 32'h3, 1'b0); cycle();
    drive(1'b1, 32'h4, 1'b0); cycle();
    drive(1'b1, 32'h6, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_zs", 32'(zero_seen), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    cycle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Empty read must not underflow the read pointer.
    drive(1'b0, 32'h0, 1'b1);
    repeat (3) cycle();
    drive(1'b1, 32'h00001234, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b0); cycle();
    chk("single_push_data", out_data, 32'h00001234);
    drive(1'b0, 32'h0, 1'b1); cycle();
    cycle();

    // Random traffic with occasional zero words and clears.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    clear = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
